// File: rtl/spm_dp_pkg.sv
// Shared constants and FSM state type for the dual-port scratchpad.
package spm_dp_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int ADDR_W_DEF = 12;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } spm_state_t;

endpackage

// File: rtl/spm_dp_if.sv
// One scratchpad access port: strobe, direction, lanes, data and range error.
interface spm_dp_if
    import spm_dp_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    localparam int BE_W = WORD_W / 8;

    logic [ADDR_W-1:0] addr;
    logic              as_;
    logic              rw;
    logic [BE_W-1:0]   be;
    logic [WORD_W-1:0] wr_data;
    logic [WORD_W-1:0] rd_data;
    logic              err;

    modport master (output addr, as_, rw, be, wr_data, input  rd_data, err);
    modport slave  (input  addr, as_, rw, be, wr_data, output rd_data, err);
endinterface

// File: rtl/spm_dp_bank.sv
// DEPTH x WORD_W storage: two synchronous ports, per-lane write enables, read returns old data.
module spm_dp_bank #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = 12
) (
    input  logic                  clk,
    input  logic                  re_a,
    input  logic [WORD_W/8-1:0]   we_a,
    input  logic [IDX_W-1:0]      addr_a,
    input  logic [WORD_W-1:0]     wdata_a,
    output logic [WORD_W-1:0]     q_a,
    input  logic                  re_b,
    input  logic [WORD_W/8-1:0]   we_b,
    input  logic [IDX_W-1:0]      addr_b,
    input  logic [WORD_W-1:0]     wdata_b,
    output logic [WORD_W-1:0]     q_b
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re_a) q_a <= mem[addr_a];
        if (re_b) q_b <= mem[addr_b];
        for (int unsigned i = 0; i < WORD_W / 8; i++) begin
            if (we_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
            if (we_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
        end
    end
endmodule

// File: rtl/spm_dp.sv
// Dual-port scratchpad (A = fetch, B = MEM): zero-fill after reset, range check,
// cross-port forwarding and B-wins lane priority on same-address dual writes.
module spm_dp
    import spm_dp_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DEPTH     = 4096,
    parameter int INIT_ZERO = 1
) (
    input  logic     clk,
    input  logic     reset,
    spm_dp_if.slave  if_spm,
    spm_dp_if.slave  mem_spm,
    output logic     spm_busy,
    output logic     spm_collision
);
    localparam int BE_W  = WORD_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    spm_state_t state, state_nxt;
    logic [IDX_W-1:0] cnt;

    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][BE_W-1:0]   be, be_wr, fwd, mask;
    logic [1:0][WORD_W-1:0] wdata, q, fdata;
    logic [1:0]             as_, rw, act, inr, rd, zero, err_r;
    logic                   same_addr;
    logic [BE_W-1:0]        overlap;

    assign addr  = {mem_spm.addr,    if_spm.addr};
    assign as_   = {mem_spm.as_,     if_spm.as_};
    assign rw    = {mem_spm.rw,      if_spm.rw};
    assign be    = {mem_spm.be,      if_spm.be};
    assign wdata = {mem_spm.wr_data, if_spm.wr_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        spm_busy  = (state == ST_INIT);
        if (state == ST_INIT && cnt == IDX_W'(DEPTH - 1)) state_nxt = ST_READY;
    end

    always_comb begin
        act   = '0;
        inr   = '0;
        rd    = '0;
        be_wr = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            act[p] = !spm_busy && (as_[p] == ENABLE_);
            inr[p] = {1'b0, addr[p]} < DEPTH_L;
            rd[p]  = act[p] && inr[p] && (rw[p] == READ);
            if (act[p] && inr[p] && (rw[p] == WRITE)) be_wr[p] = be[p];
        end
        same_addr = (addr[0] == addr[1]);
        overlap   = same_addr ? (be_wr[0] & be_wr[1]) : '0;
        // A reader sees the other port's same-cycle write lanes merged over the old word
        fwd[0]    = (rd[0] && same_addr) ? be_wr[1] : '0;
        fwd[1]    = (rd[1] && same_addr) ? be_wr[0] : '0;
    end

    spm_dp_bank #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk     (clk),
        .re_a    (rd[0]),
        .we_a    (be_wr[0] & ~overlap),
        .addr_a  (IDX_W'(addr[0])),
        .wdata_a (wdata[0]),
        .q_a     (q[0]),
        .re_b    (rd[1]),
        .we_b    (spm_busy ? {BE_W{1'b1}} : be_wr[1]),
        .addr_b  (spm_busy ? cnt : IDX_W'(addr[1])),
        .wdata_b (spm_busy ? {WORD_W{1'b0}} : wdata[1]),
        .q_b     (q[1])
    );

    // Output state is kept as flags beside the bank's read register so idle/write cycles hold rd_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero          <= '1;
            err_r         <= '0;
            mask          <= '0;
            fdata         <= '0;
            spm_collision <= 1'b0;
        end else begin
            spm_collision <= |overlap;
            for (int unsigned p = 0; p < 2; p++) begin
                err_r[p] <= act[p] && !inr[p];
                if (spm_busy || (act[p] && !inr[p])) begin
                    zero[p] <= 1'b1;
                end else if (rd[p]) begin
                    zero[p]  <= 1'b0;
                    mask[p]  <= fwd[p];
                    fdata[p] <= wdata[1 - p];
                end
            end
        end
    end

    function automatic logic [WORD_W-1:0] merge(input logic [WORD_W-1:0] old_w,
                                                 input logic [WORD_W-1:0] new_w,
                                                 input logic [BE_W-1:0]   m);
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int unsigned i = 0; i < BE_W; i++)
            if (m[i]) res[8*i +: 8] = new_w[8*i +: 8];
        return res;
    endfunction

    assign if_spm.rd_data  = zero[0] ? '0 : merge(q[0], fdata[0], mask[0]);
    assign mem_spm.rd_data = zero[1] ? '0 : merge(q[1], fdata[1], mask[1]);
    assign if_spm.err      = err_r[0];
    assign mem_spm.err     = err_r[1];
endmodule
